// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared control-word layout, opcodes, forwarding codes and operand-use helpers
package ctrl_pipe_pkg;

   localparam int CW_WIDTH       = 17;

   // Bit positions inside the 17-bit decoded control word
   localparam int BIT_REG_WRITE  = 16;
   localparam int BIT_MEM_TO_REG = 15;
   localparam int BIT_MEM_WRITE  = 14;
   localparam int BIT_MEM_READ   = 13;
   localparam int BIT_BRANCH     = 12;
   localparam int BIT_ALU_SRC    = 11;
   localparam int BIT_REG_DST    = 10;
   localparam int OPC_MSB        = 9;
   localparam int OPC_LSB        = 6;
   localparam int FUNCT_MSB      = 5;
   localparam int FUNCT_LSB      = 0;

   // Positions of RegWrite inside the narrowed EX/MEM and MEM/WB words
   localparam int MEM_REG_WRITE  = 3;
   localparam int WB_REG_WRITE   = 1;

   localparam logic [3:0] OP_BNE   = 4'b0000;
   localparam logic [3:0] OP_BEQ   = 4'b0001;
   localparam logic [3:0] OP_BGZ   = 4'b0010;
   localparam logic [3:0] OP_BLZ   = 4'b0011;
   localparam logic [3:0] OP_ADI   = 4'b0100;
   localparam logic [3:0] OP_ORI   = 4'b0101;
   localparam logic [3:0] OP_LHI   = 4'b0110;
   localparam logic [3:0] OP_LWD   = 4'b0111;
   localparam logic [3:0] OP_SWD   = 4'b1000;
   localparam logic [3:0] OP_JMP   = 4'b1001;
   localparam logic [3:0] OP_JAL   = 4'b1010;
   localparam logic [3:0] OP_RTYPE = 4'b1111;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;

   typedef struct packed {
      logic       regWrite;
      logic       memToReg;
      logic       memWrite;
      logic       memRead;
      logic       branch;
      logic       aluSrc;
      logic       regDst;
      logic [3:0] opcode;
      logic [5:0] funct;
   } ctrlWord_t;

   // Jumps and LHI never read rs
   function automatic logic usesRs(input logic [3:0] opcode);
      return !(opcode == OP_JMP || opcode == OP_JAL || opcode == OP_LHI);
   endfunction

   // rt is read by two-source R-type ops, the compare branches and stores
   function automatic logic usesRt(input logic [3:0] opcode, input logic [5:0] funct);
      return (opcode == OP_RTYPE && funct <= 6'd7) ||
             opcode == OP_BNE || opcode == OP_BEQ || opcode == OP_SWD;
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use detection and EX operand forwarding selection
module hazard_unit
   import ctrl_pipe_pkg::*;
(
   input  logic       idValid,
   input  logic [3:0] idOpcode,
   input  logic [5:0] idFunct,
   input  logic [1:0] idRs,
   input  logic [1:0] idRt,
   input  logic       exValid,
   input  logic       exMemRead,
   input  logic [3:0] exOpcode,
   input  logic [5:0] exFunct,
   input  logic [1:0] exDest,
   input  logic [1:0] exRs,
   input  logic [1:0] exRt,
   input  logic       memValid,
   input  logic       memRegWrite,
   input  logic [1:0] memDest,
   input  logic       wbValid,
   input  logic       wbRegWrite,
   input  logic [1:0] wbDest,
   output logic       loadUse,
   output logic [1:0] fwdA,
   output logic [1:0] fwdB
);

   logic memWrites;
   logic wbWrites;

   assign memWrites = memValid && memRegWrite;
   assign wbWrites  = wbValid && wbRegWrite;

   // A load in EX whose result the ID instruction needs next cycle
   always_comb begin
      loadUse = exValid && exMemRead && idValid &&
                ((exDest == idRs && usesRs(idOpcode)) ||
                 (exDest == idRt && usesRt(idOpcode, idFunct)));
   end

   // Youngest producer wins: EX/MEM before MEM/WB
   always_comb begin
      fwdA = FWD_REGFILE;
      fwdB = FWD_REGFILE;
      if (usesRs(exOpcode)) begin
         if (memWrites && memDest == exRs)
            fwdA = FWD_EXMEM;
         else if (wbWrites && wbDest == exRs)
            fwdA = FWD_MEMWB;
      end
      if (usesRt(exOpcode, exFunct)) begin
         if (memWrites && memDest == exRt)
            fwdB = FWD_EXMEM;
         else if (wbWrites && wbDest == exRt)
            fwdB = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-path pipeline registers with stall, flush and forwarding control
module ctrl_pipe
   import ctrl_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [16:0] id_ctrl,
   input  logic        id_valid,
   input  logic [1:0]  id_rs,
   input  logic [1:0]  id_rt,
   input  logic [1:0]  id_rd,
   input  logic        id_jump,
   input  logic        ex_branch_taken,
   output logic        stall,
   output logic        if_flush,
   output logic [16:0] ex_ctrl,
   output logic [3:0]  mem_ctrl,
   output logic [1:0]  wb_ctrl,
   output logic [1:0]  ex_dest,
   output logic [1:0]  mem_dest,
   output logic [1:0]  wb_dest,
   output logic        wb_valid,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] num_inst
);

   logic       exValid;
   logic [1:0] exRs;
   logic [1:0] exRt;
   logic       memValid;
   logic [1:0] idDest;
   logic       loadUse;
   logic       bubble;

   assign idDest = id_ctrl[BIT_REG_DST] ? id_rd : id_rt;
   assign bubble = ex_branch_taken || loadUse;

   // Outputs are gated by reset so a stray branch/jump input cannot leak through
   assign stall    = reset_n && loadUse && !ex_branch_taken;
   assign if_flush = reset_n && (ex_branch_taken || (id_jump && id_valid && !loadUse));

   hazard_unit uHazard (
      .idValid     (id_valid),
      .idOpcode    (id_ctrl[OPC_MSB:OPC_LSB]),
      .idFunct     (id_ctrl[FUNCT_MSB:FUNCT_LSB]),
      .idRs        (id_rs),
      .idRt        (id_rt),
      .exValid     (exValid),
      .exMemRead   (ex_ctrl[BIT_MEM_READ]),
      .exOpcode    (ex_ctrl[OPC_MSB:OPC_LSB]),
      .exFunct     (ex_ctrl[FUNCT_MSB:FUNCT_LSB]),
      .exDest      (ex_dest),
      .exRs        (exRs),
      .exRt        (exRt),
      .memValid    (memValid),
      .memRegWrite (mem_ctrl[MEM_REG_WRITE]),
      .memDest     (mem_dest),
      .wbValid     (wb_valid),
      .wbRegWrite  (wb_ctrl[WB_REG_WRITE]),
      .wbDest      (wb_dest),
      .loadUse     (loadUse),
      .fwdA        (fwd_a),
      .fwdB        (fwd_b)
   );

   // ID/EX: load the ID instruction, or an all-zero bubble on flush/hazard/empty slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_ctrl <= '0;
         exValid <= 1'b0;
         ex_dest <= '0;
         exRs    <= '0;
         exRt    <= '0;
      end else if (bubble || !id_valid) begin
         ex_ctrl <= '0;
         exValid <= 1'b0;
         ex_dest <= '0;
         exRs    <= '0;
         exRt    <= '0;
      end else begin
         ex_ctrl <= id_ctrl;
         exValid <= 1'b1;
         ex_dest <= idDest;
         exRs    <= id_rs;
         exRt    <= id_rt;
      end
   end

   // EX/MEM and MEM/WB advance unconditionally
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_ctrl <= '0;
         memValid <= 1'b0;
         mem_dest <= '0;
         wb_ctrl  <= '0;
         wb_valid <= 1'b0;
         wb_dest  <= '0;
      end else begin
         mem_ctrl <= ex_ctrl[BIT_REG_WRITE:BIT_MEM_READ];
         memValid <= exValid;
         mem_dest <= ex_dest;
         wb_ctrl  <= mem_ctrl[3:2];
         wb_valid <= memValid;
         wb_dest  <= mem_dest;
      end
   end

   // Retired-instruction counter, wraps naturally at 16 bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         num_inst <= '0;
      else if (wb_valid)
         num_inst <= num_inst + 16'd1;
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe against an instruction-level model
module tb_ctrl_pipe;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [16:0] id_ctrl;
   logic        id_valid;
   logic [1:0]  id_rs, id_rt, id_rd;
   logic        id_jump;
   logic        ex_branch_taken;
   logic        stall, if_flush;
   logic [16:0] ex_ctrl;
   logic [3:0]  mem_ctrl;
   logic [1:0]  wb_ctrl;
   logic [1:0]  ex_dest, mem_dest, wb_dest;
   logic        wb_valid;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] num_inst;

   always #5 clk = ~clk;

   ctrl_pipe dut (
      .clk(clk), .reset_n(reset_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_jump(id_jump),
      .ex_branch_taken(ex_branch_taken), .stall(stall), .if_flush(if_flush),
      .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
      .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
      .wb_valid(wb_valid), .fwd_a(fwd_a), .fwd_b(fwd_b), .num_inst(num_inst)
   );

   int nChecks = 0;
   int nFails  = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Instruction-level model: each in-flight instruction is a record moving through three slots
   typedef struct {
      bit        v;
      bit [16:0] c;
      bit [1:0]  dest;
      bit [1:0]  rs;
      bit [1:0]  rt;
   } inst_t;

   inst_t       mEx, mMem, mWb;
   int unsigned mCount;

   function automatic inst_t emptyInst();
      inst_t e;
      e.v = 0; e.c = '0; e.dest = '0; e.rs = '0; e.rt = '0;
      return e;
   endfunction

   function automatic bit readsRs(bit [16:0] c);
      int op;
      op = int'(c[9:6]);
      return !(op == 9 || op == 10 || op == 6);
   endfunction

   function automatic bit readsRt(bit [16:0] c);
      int op, f;
      op = int'(c[9:6]);
      f  = int'(c[5:0]);
      return (op == 15 && f <= 7) || op == 0 || op == 1 || op == 8;
   endfunction

   function automatic bit modelHazard();
      bit srcHit;
      srcHit = (mEx.dest == id_rs && readsRs(id_ctrl)) || (mEx.dest == id_rt && readsRt(id_ctrl));
      return mEx.v && mEx.c[13] && id_valid && srcHit;
   endfunction

   function automatic int fwdFor(bit [1:0] src);
      if (mMem.v && mMem.c[16] && mMem.dest == src) return 2;
      if (mWb.v && mWb.c[16] && mWb.dest == src) return 1;
      return 0;
   endfunction

   task automatic modelReset();
      mEx = emptyInst(); mMem = emptyInst(); mWb = emptyInst(); mCount = 0;
   endtask

   task automatic checkAll();
      bit hz;
      hz = modelHazard();
      checkVal("stall", stall, 32'(hz && !ex_branch_taken));
      checkVal("if_flush", if_flush, 32'(ex_branch_taken || (id_jump && id_valid && !hz)));
      checkVal("ex_ctrl", ex_ctrl, 32'(mEx.c));
      checkVal("mem_ctrl", mem_ctrl, 32'(mMem.c[16:13]));
      checkVal("wb_ctrl", wb_ctrl, 32'(mWb.c[16:15]));
      checkVal("ex_dest", ex_dest, 32'(mEx.dest));
      checkVal("mem_dest", mem_dest, 32'(mMem.dest));
      checkVal("wb_dest", wb_dest, 32'(mWb.dest));
      checkVal("wb_valid", wb_valid, 32'(mWb.v));
      checkVal("fwd_a", fwd_a, readsRs(mEx.c) ? 32'(fwdFor(mEx.rs)) : 32'd0);
      checkVal("fwd_b", fwd_b, readsRt(mEx.c) ? 32'(fwdFor(mEx.rt)) : 32'd0);
      checkVal("num_inst", num_inst, mCount & 32'hFFFF);
   endtask

   task automatic modelAdvance();
      bit    hz;
      inst_t n;
      hz = modelHazard();
      if (mWb.v) mCount = (mCount + 1) & 32'hFFFF;
      mWb  = mMem;
      mMem = mEx;
      if (ex_branch_taken || hz || !id_valid) begin
         mEx = emptyInst();
      end else begin
         n.v = 1; n.c = id_ctrl; n.rs = id_rs; n.rt = id_rt;
         n.dest = id_ctrl[10] ? id_rd : id_rt;
         mEx = n;
      end
   endtask

   // One cycle: check at the falling edge, advance model with the rising edge
   task automatic step();
      @(negedge clk);
      checkAll();
      @(posedge clk);
      modelAdvance();
      #1;
   endtask

   task automatic releaseReset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      modelAdvance();
      #1;
   endtask

   function automatic bit [16:0] mk(bit rw, bit mtr, bit mw, bit mr, bit rdst, bit [3:0] op, bit [5:0] f);
      return {rw, mtr, mw, mr, 1'b0, 1'b0, rdst, op, f};
   endfunction

   task automatic setId(bit v, bit [16:0] c, bit [1:0] rs, bit [1:0] rt, bit [1:0] rd, bit j);
      id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_jump = j;
   endtask

   task automatic drain();
      setId(0, '0, 0, 0, 0, 0);
      ex_branch_taken = 0;
      repeat (3) step();
   endtask

   bit [16:0] lwd, add, sub, jmp, adi;
   bit [3:0]  opTable [12];

   initial begin
      lwd = mk(1, 1, 0, 1, 0, 4'b0111, 6'd0);
      add = mk(1, 0, 0, 0, 1, 4'b1111, 6'd0);
      sub = mk(1, 0, 0, 0, 1, 4'b1111, 6'd1);
      jmp = mk(0, 0, 0, 0, 0, 4'b1001, 6'd0);
      adi = mk(1, 0, 0, 0, 0, 4'b0100, 6'd0);
      opTable = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};

      reset_n = 1'b0;
      ex_branch_taken = 1'b0;
      setId(0, '0, 0, 0, 0, 0);
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAll();
      releaseReset();

      // Load-use: one stall cycle, bubble, then MEM/WB forwarding
      setId(1, lwd, 0, 1, 0, 0); step();
      setId(1, add, 1, 2, 3, 0); #1;
      checkVal("lu_stall_on", stall, 1);
      step();
      checkVal("lu_stall_off", stall, 0);
      checkVal("lu_bubble", ex_ctrl, 0);
      step();
      setId(0, '0, 0, 0, 0, 0); #1;
      checkVal("lu_fwd_a", fwd_a, 1);
      step();
      drain();

      // Back-to-back ALU dependency via rt, then with one NOP in between
      setId(1, add, 0, 0, 2, 0); step();
      setId(1, sub, 0, 2, 3, 0); #1;
      checkVal("alu_no_stall", stall, 0);
      step();
      setId(0, '0, 0, 0, 0, 0); #1;
      checkVal("alu_fwd_b_exmem", fwd_b, 2);
      step();
      drain();
      setId(1, add, 0, 0, 2, 0); step();
      setId(0, '0, 0, 0, 0, 0); step();
      setId(1, sub, 0, 2, 3, 0); step();
      setId(0, '0, 0, 0, 0, 0); #1;
      checkVal("alu_fwd_b_memwb", fwd_b, 1);
      step();
      drain();

      // Taken branch overrides a pending load-use stall
      setId(1, lwd, 0, 1, 0, 0); step();
      setId(1, add, 1, 2, 3, 0); ex_branch_taken = 1; #1;
      checkVal("br_flush", if_flush, 1);
      checkVal("br_stall", stall, 0);
      step();
      ex_branch_taken = 0; setId(0, '0, 0, 0, 0, 0); #1;
      checkVal("br_bubble", ex_ctrl, 0);
      step();
      drain();

      // Jump flushes IF for one cycle and retires three edges later
      setId(1, jmp, 0, 0, 0, 1); #1;
      checkVal("jmp_flush", if_flush, 1);
      step();
      setId(0, '0, 0, 0, 0, 0); #1;
      checkVal("jmp_flush_once", if_flush, 0);
      step(); step();
      checkVal("jmp_wb_valid", wb_valid, 1);
      checkVal("jmp_wb_ctrl", wb_ctrl, 0);
      step();
      drain();

      // Reset during a stall
      setId(1, lwd, 0, 1, 0, 0); step();
      setId(1, add, 1, 2, 3, 0); #1;
      checkVal("rst_pre_stall", stall, 1);
      reset_n = 0; ex_branch_taken = 1; #1;
      modelReset();
      checkVal("rst_stall", stall, 0);
      checkVal("rst_flush", if_flush, 0);
      checkVal("rst_ex_ctrl", ex_ctrl, 0);
      checkVal("rst_fwd", {fwd_a, fwd_b}, 0);
      checkVal("rst_num_inst", num_inst, 0);
      ex_branch_taken = 0;
      releaseReset();
      setId(0, '0, 0, 0, 0, 0); #1;
      checkVal("rst_add_loaded", ex_ctrl, 32'(add));
      checkVal("rst_no_stall", stall, 0);
      step();
      drain();

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         bit [3:0] op;
         op = opTable[$urandom_range(0, 11)];
         id_ctrl = {1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                    1'($urandom), 1'($urandom), 1'($urandom), op, 6'($urandom_range(0, 15))};
         id_valid = ($urandom_range(0, 4) != 0);
         id_rs = 2'($urandom); id_rt = 2'($urandom); id_rd = 2'($urandom);
         id_jump = ($urandom_range(0, 7) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         step();
      end

      // Counter wrap: continuous retirement from a cleared count
      reset_n = 0; ex_branch_taken = 0; #1;
      modelReset();
      setId(1, adi, 0, 1, 0, 0);
      releaseReset();
      repeat (65536) @(posedge clk);
      #1;
      checkVal("wrap_fffe", num_inst, 16'hFFFE);
      @(posedge clk); #1;
      checkVal("wrap_ffff", num_inst, 16'hFFFF);
      @(posedge clk); #1;
      checkVal("wrap_0000", num_inst, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
